// File: rtl/id_ex_pipe_pkg.sv
// Shared decode constants for the 16-bit CPU: opcodes, register codes,
// branch / ALU / immediate-select codes and the control bundle type.
package id_ex_pipe_pkg;

    // Register codes (4 bits). GPRs R0..R7 are 0..7. Special registers use 8 and up.
    // REG0 is the "no register" code carried by unused index fields.
    localparam int         REG_CODE_W = 4;
    localparam logic [3:0] REG0 = 4'hF;
    localparam logic [3:0] SP   = 4'h8;
    localparam logic [3:0] T    = 4'h9;
    localparam logic [3:0] IH   = 4'hA;
    localparam logic [3:0] RA   = 4'hB;
    localparam logic [3:0] PC   = 4'hC;

    localparam logic [4:0] OP_ADDSP3 = 5'b00000;
    localparam logic [4:0] OP_NOP    = 5'b00001;
    localparam logic [4:0] OP_B      = 5'b00010;
    localparam logic [4:0] OP_BEQZ   = 5'b00100;
    localparam logic [4:0] OP_BNEZ   = 5'b00101;
    localparam logic [4:0] OP_SHIFT  = 5'b00110;
    localparam logic [4:0] OP_ADDIU3 = 5'b01000;
    localparam logic [4:0] OP_ADDIU  = 5'b01001;
    localparam logic [4:0] OP_SPGRP  = 5'b01100;
    localparam logic [4:0] OP_LI     = 5'b01101;
    localparam logic [4:0] OP_CMPI   = 5'b01110;
    localparam logic [4:0] OP_LW_SP  = 5'b10010;
    localparam logic [4:0] OP_LW     = 5'b10011;
    localparam logic [4:0] OP_SW_SP  = 5'b11010;
    localparam logic [4:0] OP_SW     = 5'b11011;
    localparam logic [4:0] OP_ARITH  = 5'b11100;
    localparam logic [4:0] OP_LOGIC  = 5'b11101;
    localparam logic [4:0] OP_IH     = 5'b11110;

    typedef enum logic [1:0] {
        BR_NB  = 2'd0,
        BR_B   = 2'd1,
        BR_BE  = 2'd2,
        BR_BNE = 2'd3
    } branch_e;

    typedef enum logic [3:0] {
        ALU_NO   = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_NOT  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_CMP  = 4'd8,
        ALU_MOVA = 4'd9,
        ALU_MOVB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IM0  = 3'd0,
        IM3  = 3'd1,
        IM4  = 3'd2,
        IM5  = 3'd3,
        IM8  = 3'd4,
        IM8U = 3'd5,
        IM11 = 3'd6
    } src_get_e;

    typedef struct packed {
        logic     alu_src;
        logic     mem_to_reg;
        logic     reg_write;
        logic     mem_write;
        logic     mem_read;
        logic     jump;
        branch_e  branch;
        alu_op_e  alu_op;
        src_get_e src_get;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{alu_src: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b0,
                                   mem_write: 1'b0, mem_read: 1'b0, jump: 1'b0,
                                   branch: BR_NB, alu_op: ALU_NO, src_get: IM0};

endpackage

// File: rtl/id_ex_pipe_decode.sv
// Combinational instruction decoder: instruction word to control bundle,
// register indices and illegal flag.
module id_decode_comb
    import id_ex_pipe_pkg::*;
#(
    parameter int INST_W = 16,
    parameter int REG_AW = 4
) (
    input  logic [INST_W-1:0] inst,
    output ctrl_t             ctrl,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [REG_AW-1:0] rd,
    output logic              illegal
);

    localparam logic [REG_AW-1:0] R_REG0 = REG_AW'(REG0);
    localparam logic [REG_AW-1:0] R_SP   = REG_AW'(SP);
    localparam logic [REG_AW-1:0] R_T    = REG_AW'(T);
    localparam logic [REG_AW-1:0] R_IH   = REG_AW'(IH);
    localparam logic [REG_AW-1:0] R_PC   = REG_AW'(PC);

    logic [4:0]        op;
    logic [2:0]        rx;
    logic [2:0]        ry;
    logic [4:0]        func;
    logic [REG_AW-1:0] gx, gy, gz;

    assign op   = inst[15:11];
    assign rx   = inst[10:8];
    assign ry   = inst[7:5];
    assign func = inst[4:0];
    assign gx   = REG_AW'(inst[10:8]);
    assign gy   = REG_AW'(inst[7:5]);
    assign gz   = REG_AW'(inst[4:2]);

    // Full decode; anything unrecognised collapses to a NOP bundle with illegal set.
    always_comb begin
        ctrl    = CTRL_NOP;
        rs1     = R_REG0;
        rs2     = R_REG0;
        rd      = R_REG0;
        illegal = 1'b0;
        case (op)
            OP_ADDSP3: begin
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
                ctrl.alu_op = ALU_ADD; ctrl.src_get = IM8;
                rs1 = R_SP; rd = gx;
            end
            OP_NOP: illegal = (inst[10:0] != 11'd0);
            OP_B: begin
                ctrl.branch = BR_B; ctrl.src_get = IM11;
            end
            OP_BEQZ, OP_BNEZ: begin
                ctrl.branch = (op == OP_BEQZ) ? BR_BE : BR_BNE;
                ctrl.src_get = IM8; rs1 = gx;
            end
            OP_SHIFT: begin
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.src_get = IM3;
                rs1 = gy; rd = gx;
                case (func[1:0])
                    2'b00:   ctrl.alu_op = ALU_SLL;
                    2'b11:   ctrl.alu_op = ALU_SRA;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDIU3, OP_ADDIU: begin
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD;
                ctrl.src_get = (op == OP_ADDIU) ? IM8 : IM4;
                rs1 = gx; rd = (op == OP_ADDIU) ? gx : gy;
            end
            OP_SPGRP: begin
                case (rx)
                    3'b000, 3'b001: begin
                        ctrl.branch = (rx == 3'b000) ? BR_BE : BR_BNE;
                        ctrl.src_get = IM8; rs1 = R_T;
                    end
                    3'b011: begin
                        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
                        ctrl.alu_op = ALU_ADD; ctrl.src_get = IM8;
                        rs1 = R_SP; rd = R_SP;
                    end
                    3'b100: begin
                        ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_MOVA;
                        rs1 = gy; rd = R_SP;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_LI: begin
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
                ctrl.alu_op = ALU_MOVB; ctrl.src_get = IM8U; rd = gx;
            end
            OP_CMPI: begin
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
                ctrl.alu_op = ALU_CMP; ctrl.src_get = IM8;
                rs1 = gx; rd = R_T;
            end
            OP_LW_SP, OP_LW: begin
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1;
                ctrl.mem_to_reg = 1'b1; ctrl.alu_op = ALU_ADD;
                ctrl.src_get = (op == OP_LW) ? IM5 : IM8;
                rs1 = (op == OP_LW) ? gx : R_SP;
                rd  = (op == OP_LW) ? gy : gx;
            end
            OP_SW_SP, OP_SW: begin
                ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD;
                ctrl.src_get = (op == OP_SW) ? IM5 : IM8;
                rs1 = (op == OP_SW) ? gx : R_SP;
                rs2 = (op == OP_SW) ? gy : gx;
            end
            OP_ARITH: begin
                ctrl.reg_write = 1'b1; rs1 = gx; rs2 = gy; rd = gz;
                case (func[1:0])
                    2'b01:   ctrl.alu_op = ALU_ADD;
                    2'b11:   ctrl.alu_op = ALU_SUB;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOGIC: begin
                case (func)
                    5'b01100, 5'b01101: begin
                        ctrl.reg_write = 1'b1;
                        ctrl.alu_op = (func == 5'b01100) ? ALU_AND : ALU_OR;
                        rs1 = gx; rs2 = gy; rd = gx;
                    end
                    5'b01010: begin
                        ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_CMP;
                        rs1 = gx; rs2 = gy; rd = R_T;
                    end
                    5'b01111: begin
                        ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_NOT;
                        rs1 = gy; rd = gx;
                    end
                    5'b00000: begin
                        case (ry)
                            3'b000: begin ctrl.jump = 1'b1; rs1 = gx; end
                            3'b010: begin
                                ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_MOVA;
                                rs1 = R_PC; rd = gx;
                            end
                            default: illegal = 1'b1;
                        endcase
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_IH: begin
                ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_MOVA;
                case (func)
                    5'b00000: begin rs1 = R_IH; rd = gx;   end
                    5'b00001: begin rs1 = gx;   rd = R_IH; end
                    default:  illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl = CTRL_NOP;
            rs1  = R_REG0;
            rs2  = R_REG0;
            rd   = R_REG0;
        end
    end

endmodule

// File: rtl/id_ex_pipe.sv
// Registered decode stage: decoder, load-use hazard detection, flush/stall
// priority, ID/EX pipeline register and saturating stall counter.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int INST_W = 16,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [INST_W-1:0] if_inst,
    input  logic [INST_W-1:0] if_pc,
    output logic              id_ready,
    input  logic              ex_stall,
    input  logic              ex_flush,
    output logic              ex_valid,
    output logic              ex_alu_src,
    output logic              ex_mem_to_reg,
    output logic              ex_reg_write,
    output logic              ex_mem_write,
    output logic              ex_mem_read,
    output logic              ex_jump,
    output logic [1:0]        ex_branch,
    output logic [3:0]        ex_alu_op,
    output logic [2:0]        ex_src_get,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [INST_W-1:0] ex_pc,
    output logic              ex_illegal,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [REG_AW-1:0] R_REG0 = REG_AW'(REG0);

    ctrl_t             dec_ctrl;
    logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
    logic              dec_illegal;

    id_decode_comb #(.INST_W(INST_W), .REG_AW(REG_AW)) u_dec (
        .inst    (if_inst),
        .ctrl    (dec_ctrl),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .rd      (dec_rd),
        .illegal (dec_illegal)
    );

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [INST_W-1:0] pc_q, pc_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hazard;

    // A load in ID/EX whose destination the decoding instruction reads.
    assign hazard = if_valid && valid_q && ctrl_q.mem_read && (rd_q != R_REG0) &&
                    ((dec_rs1 == rd_q) || (dec_rs2 == rd_q));

    // Priority: flush, then stall hold, then load-use bubble, then normal issue.
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        pc_d      = pc_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        id_ready  = 1'b0;
        if (ex_flush || (!ex_stall && (hazard || !if_valid))) begin
            valid_d   = 1'b0;
            ctrl_d    = CTRL_NOP;
            rs1_d     = R_REG0;
            rs2_d     = R_REG0;
            rd_d      = R_REG0;
            pc_d      = '0;
            illegal_d = 1'b0;
        end else if (!ex_stall) begin
            valid_d   = 1'b1;
            ctrl_d    = dec_ctrl;
            rs1_d     = dec_rs1;
            rs2_d     = dec_rs2;
            rd_d      = dec_rd;
            pc_d      = if_pc;
            illegal_d = dec_illegal;
        end
        if (ex_flush) begin
            id_ready = 1'b1;
        end else if (!ex_stall) begin
            id_ready = !hazard;
            if (hazard && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // ID/EX register and stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_NOP;
            rs1_q     <= R_REG0;
            rs2_q     <= R_REG0;
            rd_q      <= R_REG0;
            pc_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_jump       = ctrl_q.jump;
    assign ex_branch     = ctrl_q.branch;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_src_get    = ctrl_q.src_get;
    assign ex_rs1        = rs1_q;
    assign ex_rs2        = rs2_q;
    assign ex_rd         = rd_q;
    assign ex_pc         = pc_q;
    assign ex_illegal    = illegal_q;
    assign stall_cnt     = cnt_q;

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Registered decode stage of the 16-bit pipelined CPU, between the IF/ID register and EX. Decodes each accepted instruction into the existing control bundle and register indices, and registers the result into an ID/EX pipeline register with a valid bit. Adds what the combinational decoder lacks:
- a complete default decode with an illegal-instruction flag;
- load-use hazard detection with one-cycle bubble insertion;
- downstream stall hold and branch flush;
- a saturating stall-cycle counter.

## Interface
Parameters:
- INST_W, 16, instruction and PC width.
- REG_AW, 4, register index width; must be ≥4; GPR indices zero-extended; special codes REG0/SP/T/IH/RA/PC from config.v.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- if_valid  in  1  IF/ID holds an instruction.
- if_inst  in  INST_W  instruction word.
- if_pc  in  INST_W  PC of that instruction.
- id_ready  out  1  stage consumes if_inst this cycle.
- ex_stall  in  1  EX cannot accept; hold ID/EX.
- ex_flush  in  1  taken branch/jump resolved in EX; kill younger instructions.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_write, ex_mem_read, ex_jump  out  1 each  control bits.
- ex_branch  out  2  NB/B/BE/BNE code.
- ex_alu_op  out  4  ALU op code.
- ex_src_get  out  3  immediate-select code.
- ex_rs1, ex_rs2, ex_rd  out  REG_AW each  source/destination indices.
- ex_pc  out  INST_W  PC of the ID/EX instruction.
- ex_illegal  out  1  the ID/EX instruction failed to decode.
- stall_cnt  out  CNT_W  count of load-use bubble cycles.

## Operation
Decode:
- Fields: op = inst[15:11], rx = inst[10:8], ry = inst[7:5], rz = inst[4:2], func = inst[4:0].
- Sub-decode uses rx for the ADDSP group, func for the NOT/MFIH groups, func[1:0] for the SLL group, and ry for the JR/MFPC subgroup.
- Every op/sub-op combination produces a fully defined bundle. Unlisted combinations decode as NOP with ex_illegal=1.
- A NOP bundle is: all enables 0, branch NB, alu_op no_alu_op, src_get IM0, all indices REG0.
- The MTIH encoding uses func 00001 and must not alias MFIH (00000).

Load-use hazard:
- Condition: ID/EX holds a valid instruction with ex_mem_read=1 and ex_rd≠REG0, and the decoding instruction (if_valid=1) reads rs1 or rs2 equal to ex_rd.
- On hazard: id_ready=0, the instruction stays in IF/ID, a bubble is loaded into ID/EX, and stall_cnt increments (saturating at all-ones).

Priority, highest first:
1. rst: reset state.
2. ex_flush: ID/EX loads a bubble; id_ready=1 so IF/ID is dropped. Not counted as a stall.
3. ex_stall: ID/EX holds its value; id_ready=0.
4. Load-use hazard: as above.
5. Normal: if if_valid=1, load decoded bundle with ex_valid=1 and id_ready=1; otherwise load a bubble.

Bubble contents: ex_valid=0, NOP bundle, ex_illegal=0, ex_pc=0.

## Timing
- Reset values: ex_valid=0; every control output 0; ex_branch=NB; ex_alu_op=no_alu_op; ex_src_get=IM0; rs1/rs2/rd=REG0; ex_pc=0; ex_illegal=0; stall_cnt=0.
- id_ready is combinational from if_valid, if_inst, ID/EX state, ex_stall and ex_flush.
- Latency: an accepted instruction appears on ex_* at the next rising edge (1 cycle).
- A load-use pair costs exactly one bubble. After the bubble, ID/EX no longer holds the load, so the dependent instruction issues on the following edge.
- Simultaneous ex_flush and hazard: flush wins; no count.
- Simultaneous ex_stall and hazard: hold; no count.
- Reset asserted mid-stall: all outputs return to reset values immediately (asynchronous); the counter clears.

## Structure
- Shared constants live in config.v: opcodes, register codes (REG0, SP, T, IH, RA, PC), branch codes, ALU op codes, src_get codes. Widen the register codes to REG_AW there.
- One sub-module, id_decode_comb: purely combinational, maps inst to the control bundle plus illegal flag, with no latches.
- The top module holds the hazard logic, priority mux, ID/EX register and counter.

## Test plan
- Reset then idle: rst=0 for 2 cycles, then if_valid=0 → ex_valid=0, ex_alu_op=no_alu_op, stall_cnt=0.
- ADDIU R1,5 (0x4905) at pc 0x0010 → next cycle ex_valid=1, ex_reg_write=1, ex_alu_src=1, ex_rd=1, ex_src_get=IM8, ex_pc=0x0010.
- Load-use: LW R2←[R1+0] (0x9940), then ADDU R2,R3→R4 (0xE271):
  - cycle after LW: id_ready=0, next ex_valid=0, stall_cnt=1;
  - the cycle after: ADDU issues with ex_rs1=2.
- ex_flush=1 during the load-use stall → bubble loaded, id_ready=1, stall_cnt unchanged.
- ex_stall=1 for 3 cycles with ADDIU in ID/EX → ex_* constant, id_ready=0 for all 3 cycles.
- Illegal word 0xF800 → ex_valid=1, ex_illegal=1, all write enables 0. With CNT_W=2, repeated load-use stalls saturate stall_cnt at 3.
